// File: rtl/adc_sample_filter_if.sv
// Sample-stream and result bundle between the ADC control block, the sample
// filter and the downstream phase detector / loop filter.
interface adc_sample_filter_if #(
    parameter int DATA_W   = 8,
    parameter int PERIOD_W = 16
);
    logic [DATA_W-1:0]   SAMPLE_in;
    logic                SAMPLE_valid;
    logic [DATA_W-1:0]   AVG_out;
    logic                AVG_valid;
    logic                LEVEL;
    logic                EDGE;
    logic [PERIOD_W-1:0] PERIOD_out;
    logic                PERIOD_valid;
    logic                PERIOD_ovf;
    logic                WARM;

    modport master (
        output SAMPLE_in, SAMPLE_valid,
        input  AVG_out, AVG_valid, LEVEL, EDGE,
        input  PERIOD_out, PERIOD_valid, PERIOD_ovf, WARM
    );

    modport slave (
        input  SAMPLE_in, SAMPLE_valid,
        output AVG_out, AVG_valid, LEVEL, EDGE,
        output PERIOD_out, PERIOD_valid, PERIOD_ovf, WARM
    );
endinterface

// File: rtl/adc_sample_filter.sv
// Power-of-two moving average, hysteresis squarer and rising-crossing period
// counter for the PLL front end.
module adc_sample_filter #(
    parameter int DATA_W     = 8,
    parameter int LOG2_DEPTH = 2,
    parameter int MID        = 128,
    parameter int HYST       = 8,
    parameter int PERIOD_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    adc_sample_filter_if.slave bus
);
    localparam int DEPTH   = 1 << LOG2_DEPTH;
    localparam int SUM_W   = DATA_W + LOG2_DEPTH;
    localparam int PTR_W   = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int CNT_W   = LOG2_DEPTH + 1;
    localparam int DMAX    = (1 << DATA_W) - 1;
    localparam int TH_HI_I = (MID + HYST > DMAX) ? DMAX : MID + HYST;
    localparam int TH_LO_I = (MID - HYST < 0) ? 0 : MID - HYST;
    localparam logic [DATA_W-1:0]   TH_HI = TH_HI_I[DATA_W-1:0];
    localparam logic [DATA_W-1:0]   TH_LO = TH_LO_I[DATA_W-1:0];
    localparam logic [PERIOD_W-1:0] PMAX  = '1;
    localparam logic [CNT_W-1:0]    FULL  = CNT_W'(DEPTH);

    typedef enum logic {WARM_ST, RUN_ST} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   samp_buf_q [DEPTH];
    logic [DATA_W-1:0]   oldest;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [PTR_W-1:0]    wptr_q, wptr_d;
    logic [CNT_W-1:0]    fill_q, fill_d;
    logic [DATA_W-1:0]   avg_q, avg_d;
    logic                avg_valid_q, avg_valid_d;
    logic                warm_q, warm_d;
    logic                level_q, level_d;
    logic                edge_q, edge_d;
    logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
    logic                armed_q, armed_d;
    logic [PERIOD_W-1:0] pout_q, pout_d;
    logic                pvalid_q, pvalid_d;
    logic                povf_q, povf_d;

    // A single-entry window always replaces entry 0.
    if (LOG2_DEPTH == 0) begin : g_one
        assign oldest = samp_buf_q[0];
    end else begin : g_many
        assign oldest = samp_buf_q[wptr_q];
    end

    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        wptr_d      = wptr_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (bus.SAMPLE_valid) begin
            sum_d  = sum_q + SUM_W'(bus.SAMPLE_in) - SUM_W'(oldest);
            wptr_d = (LOG2_DEPTH == 0) ? '0 : PTR_W'(wptr_q + 1'b1);
            case (state_q)
                WARM_ST: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_d == FULL) begin
                        state_d     = RUN_ST;
                        avg_valid_d = 1'b1;
                    end
                end
                default: avg_valid_d = 1'b1;
            endcase
            if (avg_valid_d) begin
                avg_d = sum_d[SUM_W-1:LOG2_DEPTH];
            end
        end
        warm_d = (state_d == WARM_ST);
    end

    // Comparator looks at the registered average, so it trails AVG_valid by one cycle.
    always_comb begin
        level_d = level_q;
        if (avg_valid_q) begin
            if (avg_q >= TH_HI) begin
                level_d = 1'b1;
            end else if (avg_q <= TH_LO) begin
                level_d = 1'b0;
            end
        end
        edge_d = level_d & ~level_q;
    end

    always_comb begin
        pcnt_d   = (pcnt_q == PMAX) ? pcnt_q : pcnt_q + 1'b1;
        armed_d  = armed_q;
        pout_d   = pout_q;
        pvalid_d = 1'b0;
        povf_d   = povf_q;
        if (edge_d) begin
            pcnt_d  = PERIOD_W'(1);
            armed_d = 1'b1;
            if (armed_q) begin
                pout_d   = pcnt_q;
                pvalid_d = 1'b1;
                povf_d   = (pcnt_q == PMAX);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                samp_buf_q[i] <= '0;
            end
        end else if (bus.SAMPLE_valid) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wptr_q == PTR_W'(i)) begin
                    samp_buf_q[i] <= bus.SAMPLE_in;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= WARM_ST;
            sum_q       <= '0;
            wptr_q      <= '0;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            warm_q      <= 1'b1;
            level_q     <= 1'b0;
            edge_q      <= 1'b0;
            pcnt_q      <= '0;
            armed_q     <= 1'b0;
            pout_q      <= '0;
            pvalid_q    <= 1'b0;
            povf_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            wptr_q      <= wptr_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            warm_q      <= warm_d;
            level_q     <= level_d;
            edge_q      <= edge_d;
            pcnt_q      <= pcnt_d;
            armed_q     <= armed_d;
            pout_q      <= pout_d;
            pvalid_q    <= pvalid_d;
            povf_q      <= povf_d;
        end
    end

    assign bus.AVG_out      = avg_q;
    assign bus.AVG_valid    = avg_valid_q;
    assign bus.LEVEL        = level_q;
    assign bus.EDGE         = edge_q;
    assign bus.PERIOD_out   = pout_q;
    assign bus.PERIOD_valid = pvalid_q;
    assign bus.PERIOD_ovf   = povf_q;
    assign bus.WARM         = warm_q;
endmodule

// File: tb/tb_adc_sample_filter.sv
// Three filter configurations share one random sample stream; each is checked
// every cycle against a window-history reference model.
module tb_adc_sample_filter;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [7:0] samp = 8'd0;
    logic       sv = 1'b0;

    always #5 CLK = ~CLK;

    adc_sample_filter_if #(.DATA_W(8), .PERIOD_W(16)) if0 ();
    adc_sample_filter_if #(.DATA_W(8), .PERIOD_W(16)) if1 ();
    adc_sample_filter_if #(.DATA_W(8), .PERIOD_W(6))  if2 ();

    assign if0.SAMPLE_in = samp;
    assign if0.SAMPLE_valid = sv;
    assign if1.SAMPLE_in = samp;
    assign if1.SAMPLE_valid = sv;
    assign if2.SAMPLE_in = samp;
    assign if2.SAMPLE_valid = sv;

    adc_sample_filter #(.DATA_W(8), .LOG2_DEPTH(2), .MID(128), .HYST(8), .PERIOD_W(16))
        dut0 (.CLK(CLK), .RST(RST), .bus(if0));
    adc_sample_filter #(.DATA_W(8), .LOG2_DEPTH(0), .MID(128), .HYST(8), .PERIOD_W(16))
        dut1 (.CLK(CLK), .RST(RST), .bus(if1));
    adc_sample_filter #(.DATA_W(8), .LOG2_DEPTH(3), .MID(20), .HYST(40), .PERIOD_W(6))
        dut2 (.CLK(CLK), .RST(RST), .bus(if2));

    // Reference configuration, mirroring the three instances above.
    int m_l2 [3] = '{2, 0, 3};
    int m_mid[3] = '{128, 128, 20};
    int m_hys[3] = '{8, 8, 40};
    int m_pw [3] = '{16, 16, 6};
    int th_hi[3], th_lo[3], pmax[3];

    // Reference state: newest sample at hist[k][0].
    int hist [3][16];
    int cnt  [3];
    int e_avg[3], e_avgv[3], e_lvl[3], e_edg[3];
    int pc   [3], armed[3];
    int e_pout[3], e_pv[3], e_povf[3], e_warm[3];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_value(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset(input int k);
        for (int i = 0; i < 16; i++) hist[k][i] = 0;
        cnt[k] = 0;
        e_avg[k] = 0; e_avgv[k] = 0; e_lvl[k] = 0; e_edg[k] = 0;
        pc[k] = 0; armed[k] = 0;
        e_pout[k] = 0; e_pv[k] = 0; e_povf[k] = 0; e_warm[k] = 1;
    endtask

    task automatic model_step(input int k);
        int depth, sum, prev_lvl;
        depth = 1 << m_l2[k];
        if (!RST) begin
            model_reset(k);
            return;
        end
        prev_lvl = e_lvl[k];
        if (e_avgv[k] != 0) begin
            if (e_avg[k] >= th_hi[k]) e_lvl[k] = 1;
            else if (e_avg[k] <= th_lo[k]) e_lvl[k] = 0;
        end
        e_edg[k] = (e_lvl[k] == 1 && prev_lvl == 0) ? 1 : 0;
        e_pv[k] = 0;
        if (e_edg[k] != 0) begin
            if (armed[k] != 0) begin
                e_pout[k] = pc[k];
                e_pv[k] = 1;
                e_povf[k] = (pc[k] == pmax[k]) ? 1 : 0;
            end
            armed[k] = 1;
            pc[k] = 1;
        end else if (pc[k] < pmax[k]) begin
            pc[k]++;
        end
        e_avgv[k] = 0;
        if (sv) begin
            for (int i = 15; i > 0; i--) hist[k][i] = hist[k][i-1];
            hist[k][0] = int'(samp);
            if (cnt[k] < depth) cnt[k]++;
            if (cnt[k] == depth) begin
                sum = 0;
                for (int i = 0; i < depth; i++) sum += hist[k][i];
                e_avg[k] = sum / depth;
                e_avgv[k] = 1;
            end
        end
        e_warm[k] = (cnt[k] < depth) ? 1 : 0;
    endtask

    task automatic cmp_inst(input int k, input int avg, input int avgv, input int lvl,
                            input int edg, input int pout, input int pv, input int povf,
                            input int warm);
        check_value($sformatf("AVG_out[%0d]", k), avg, e_avg[k]);
        check_value($sformatf("AVG_valid[%0d]", k), avgv, e_avgv[k]);
        check_value($sformatf("LEVEL[%0d]", k), lvl, e_lvl[k]);
        check_value($sformatf("EDGE[%0d]", k), edg, e_edg[k]);
        check_value($sformatf("PERIOD_out[%0d]", k), pout, e_pout[k]);
        check_value($sformatf("PERIOD_valid[%0d]", k), pv, e_pv[k]);
        check_value($sformatf("PERIOD_ovf[%0d]", k), povf, e_povf[k]);
        check_value($sformatf("WARM[%0d]", k), warm, e_warm[k]);
    endtask

    // Apply one cycle of inputs, advance the model at the edge, compare at the falling edge.
    task automatic cycle(input logic r, input logic v, input logic [7:0] s);
        RST = r;
        sv = v;
        samp = s;
        @(posedge CLK);
        for (int k = 0; k < 3; k++) model_step(k);
        @(negedge CLK);
        cmp_inst(0, int'(if0.AVG_out), int'(if0.AVG_valid), int'(if0.LEVEL), int'(if0.EDGE),
                 int'(if0.PERIOD_out), int'(if0.PERIOD_valid), int'(if0.PERIOD_ovf), int'(if0.WARM));
        cmp_inst(1, int'(if1.AVG_out), int'(if1.AVG_valid), int'(if1.LEVEL), int'(if1.EDGE),
                 int'(if1.PERIOD_out), int'(if1.PERIOD_valid), int'(if1.PERIOD_ovf), int'(if1.WARM));
        cmp_inst(2, int'(if2.AVG_out), int'(if2.AVG_valid), int'(if2.LEVEL), int'(if2.EDGE),
                 int'(if2.PERIOD_out), int'(if2.PERIOD_valid), int'(if2.PERIOD_ovf), int'(if2.WARM));
        for (int k = 0; k < 3; k++) begin
            if (e_pv[k] != 0)
                $display("period inst%0d = %0d cycles ovf=%0d at %0t", k, e_pout[k], e_povf[k], $time);
        end
    endtask

    initial begin
        int phase_left, phase_hi, phase_floor, vprob, rst_left;
        logic [7:0] s;
        logic v;

        for (int k = 0; k < 3; k++) begin
            th_hi[k] = (m_mid[k] + m_hys[k] > 255) ? 255 : m_mid[k] + m_hys[k];
            th_lo[k] = (m_mid[k] - m_hys[k] < 0) ? 0 : m_mid[k] - m_hys[k];
            pmax[k]  = (1 << m_pw[k]) - 1;
            model_reset(k);
        end

        // Reset with strobes present, then warm-up and sliding-window truncation.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'd100);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'd200);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b1, 8'd201);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'd0);

        phase_left = 0;
        phase_hi = 1;
        phase_floor = 0;
        vprob = 4;
        rst_left = 0;
        for (int n = 0; n < 4000; n++) begin
            if (phase_left == 0) begin
                phase_hi = 1 - phase_hi;
                phase_floor = int'($urandom_range(0, 1));
                phase_left = int'($urandom_range(15, 130));
                vprob = int'($urandom_range(1, 4));
            end
            phase_left--;
            if (n == 2000 || $urandom_range(0, 699) == 0) rst_left = int'($urandom_range(1, 3));
            v = ($urandom_range(0, 3) < vprob);
            if ($urandom_range(0, 9) == 0) s = 8'($urandom_range(110, 145));
            else if (phase_hi != 0) s = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom_range(150, 254));
            else s = (phase_floor != 0) ? 8'd0 : 8'($urandom_range(1, 100));
            if (rst_left > 0) begin
                rst_left--;
                cycle(1'b0, v, s);
            end else begin
                cycle(1'b1, v, s);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/adc_sample_filter.md
Name: adc_sample_filter

Overview:
Downstream consumer of the ADC control block's 8-bit sample stream (DATA_out plus a one-cycle sample strobe) in the PLL front end.
- Smooths samples with a power-of-two moving average.
- Squares the filtered signal with a hysteresis comparator.
- Measures the clock-cycle period between rising crossings for the loop filter / phase detector.

Parameters:
DATA_W, 8, sample and average width
LOG2_DEPTH, 2, log2 of moving-average depth; legal 0..4 (DEPTH = 2^LOG2_DEPTH)
MID, 128, comparator midpoint
HYST, 8, hysteresis half-width; thresholds TH_HI = MID+HYST clamped to 255, TH_LO = MID-HYST clamped to 0
PERIOD_W, 16, period counter width

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  synchronous active-low reset (RST==0 at posedge resets)
SAMPLE_in  input  DATA_W  sample from ADC control block
SAMPLE_valid  input  1  one-cycle strobe, SAMPLE_in valid; may assert every cycle
AVG_out  output  DATA_W  filtered sample
AVG_valid  output  1  one-cycle strobe, AVG_out updated
LEVEL  output  1  hysteresis comparator output
EDGE  output  1  one-cycle pulse on LEVEL 0->1
PERIOD_out  output  PERIOD_W  CLK cycles between last two EDGE pulses
PERIOD_valid  output  1  one-cycle strobe, PERIOD_out updated
PERIOD_ovf  output  1  last reported period saturated
WARM  output  1  high while the buffer holds fewer than DEPTH samples since reset

Behaviour:
Reset (RST==0 at posedge):
- Sample buffer, running sum, write pointer and fill count cleared.
- AVG_out, AVG_valid, LEVEL, EDGE, PERIOD_out, PERIOD_valid, PERIOD_ovf all 0; WARM=1.
- Period counter cleared; armed flag cleared.
- SAMPLE_valid ignored while RST==0.
- Reset mid-operation discards all history: next AVG_valid only after DEPTH fresh samples.

Averager:
- States WARM_ST -> RUN_ST.
- Running sum width DATA_W+LOG2_DEPTH; no overflow possible.
- On each SAMPLE_valid:
  - sum <= sum + SAMPLE_in - buf[wptr];
  - buf[wptr] <= SAMPLE_in;
  - wptr wraps modulo DEPTH.
- WARM_ST: fill count increments per sample. The sample that brings the count to DEPTH moves the state to RUN_ST and produces the first AVG_valid. WARM drops in the same cycle.
- RUN_ST: every SAMPLE_valid produces AVG_valid.
- AVG_out = new sum >> LOG2_DEPTH (truncate), registered.
- AVG_valid asserts the cycle after SAMPLE_valid (latency 1). AVG_out holds between strobes.
- LOG2_DEPTH=0: pass-through with latency 1; first sample already valid; WARM=0 after first sample.

Comparator:
- Evaluated only on AVG_valid cycles; result registered, so latency 1 after AVG_valid (2 after SAMPLE_valid).
- LEVEL<=1 if AVG_out >= TH_HI.
- LEVEL<=0 if AVG_out <= TH_LO.
- Otherwise LEVEL holds.
- EDGE pulses in the same cycle LEVEL goes 0->1; no pulse on 1->0.

Period counter:
- Increments every cycle, saturates at all-ones.
- On an EDGE cycle, counter loads 1.
- If armed: PERIOD_out <= counter value and PERIOD_valid pulses in the EDGE cycle. PERIOD_ovf <= (counter == all-ones), held until the next report.
- The first EDGE after reset only sets armed; it produces no PERIOD_valid.
- Period value = exact CLK-cycle distance between consecutive EDGE pulses.

Test Plan:
1. Reset: RST=0 for 3 cycles with SAMPLE_valid=1, SAMPLE_in=200 -> all outputs 0, WARM=1. After release, first AVG_valid requires 4 new samples.
2. Warm-up (LOG2_DEPTH=2): four strobes of 100 -> no AVG_valid for samples 1-3; AVG_valid with AVG_out=100 one cycle after sample 4; WARM 1->0 then.
3. Sliding window: continue with back-to-back strobes of 200 -> AVG_out 125,150,175,200 on consecutive cycles. Then 201,201,201,201 -> AVG_out 200,200,200,201 (truncation).
4. Hysteresis (LOG2_DEPTH=0, MID=128, HYST=8): samples 130,136,125,121,120,119,136 -> LEVEL 0,1,1,1,0,0,1. EDGE pulses at 136 (twice only), each 2 cycles after the strobe.
5. Period: rising crossings 50 cycles apart -> first EDGE no PERIOD_valid; second gives PERIOD_out=50, PERIOD_valid=1, PERIOD_ovf=0.
6. Saturation plus reset mid-run (PERIOD_W=6): EDGEs 100 cycles apart -> PERIOD_out=63, PERIOD_ovf=1. Then RST=0 for 1 cycle in RUN_ST -> LEVEL=0, armed cleared, WARM=1; the next EDGE yields no PERIOD_valid.
